piece_sequencer: RTL
====================

# piece_sequencer

- Sequences the falling tetromino against the 10x20 `board` store: accepts a spawned piece, probes occupancy cell by cell, and moves it down one row per gravity step.
- When the piece is blocked it locks the piece: writes its four cells, triggers the board's line-clear validation and accumulates cleared lines.
- Sits between the piece generator/gravity timer and `board`, and is the only driver of the board's write/probe port.

## Interface
- `COLOUR_W`, 24: colour width; matches the board store.
- `LINES_W`, 16: width of the cleared-lines counter.

Ports (clock and reset first):
- `clk` in 1: the block's single clock.
- `rst` in 1: reset, asynchronous, active-low.
- `piece_valid` in 1: spawn request.
- `piece_cells` in 36: four cells, each `{y[4:0],x[3:0]}`; cell k is at `[9k+8:9k]`.
- `piece_colour` in COLOUR_W: colour of the piece.
- `piece_ready` out 1: high only in IDLE; spawn accepted when `piece_valid && piece_ready`.
- `step` in 1: gravity tick, one cycle.
- `board_x` out 4, `board_y` out 5: board address for probe or write.
- `write_colour` out COLOUR_W: write data.
- `validate_start` out 1: board write enable.
- `write_done` out 1: one-cycle pulse that starts validation.
- `occupied` in 1: combinational occupancy at `board_x`/`board_y`.
- `lines_cleared` in 2: rows cleared by the last validation.
- `validate_done_flag` in 1: validation finished.
- `cur_cells` out 36: current piece position.
- `busy` out 1: high in any state other than IDLE, ACTIVE or GAME_OVER.
- `locked` out 1: one-cycle pulse when a lock completes.
- `game_over` out 1: sticky.
- `lines_total` out LINES_W: saturating count of cleared lines.

## Operation
States: IDLE, SPAWN_CHK, ACTIVE, FALL_CHK, MOVE, WRITE, COMMIT, WAIT_VAL, GAME_OVER.

- **IDLE:** on accept, latch `piece_cells` into `cur_cells` and `piece_colour`, clear index k, go to SPAWN_CHK.
- **SPAWN_CHK:** one cycle per cell, k = 0..3.
  - Drive cell k. A cell is a collision if `occupied`, or if x > 9 or y > 19.
  - After k = 3: any collision -> GAME_OVER, else -> ACTIVE.
- **ACTIVE:** wait for `step`. When `step` is seen, go to FALL_CHK with k = 0.
- **FALL_CHK:** one cycle per cell.
  - If cell k has y = 19: blocked. Drive its own address; ignore `occupied`.
  - Otherwise drive (x, y+1); `occupied` means blocked.
  - After k = 3: blocked -> WRITE, else -> MOVE.
- **MOVE:** add 1 to all four y fields of `cur_cells`, then -> ACTIVE.
- **WRITE:** 4 cycles. `validate_start` = 1, drive cell k and `write_colour` = latched colour, then -> COMMIT.
- **COMMIT:** `write_done` = 1 for one cycle, then -> WAIT_VAL.
- **WAIT_VAL:** hold until `validate_done_flag` = 1. On that cycle:
  - `lines_total += lines_cleared`, saturating at 2^LINES_W-1.
  - `locked` = 1.
  - -> IDLE.
- **GAME_OVER:** absorbing; only reset leaves it. `piece_ready` = 0 and `step` is ignored.

Board-side defaults: outside WRITE, `validate_start` = 0. Outside SPAWN_CHK, FALL_CHK and WRITE, `board_x` = 0 and `board_y` = 0.

Cell probes never self-collide, because the piece is not in the board until lock.

## Timing
- Reset (async, immediate) sets:
  - state IDLE;
  - `cur_cells`, `board_x`, `board_y`, `write_colour`, `lines_total` = 0;
  - `validate_start`, `write_done`, `locked`, `game_over` = 0;
  - `piece_ready` = 1.
- Reset during WRITE aborts the write. A partially written piece stays in the board; clearing the board is the board's own reset.
- Spawn: accept at cycle 0; SPAWN_CHK occupies cycles 1-4; ACTIVE from cycle 5.
- Step, unblocked: FALL_CHK 4 cycles, MOVE 1 cycle; back in ACTIVE 6 cycles after `step`.
- Lock: FALL_CHK 4, WRITE 4, COMMIT 1, then WAIT_VAL for N ≥ 1 cycles; `locked` is asserted on the last WAIT_VAL cycle.
- `step` outside ACTIVE is dropped, not queued.
- `piece_valid` outside IDLE is ignored. The generator must hold `piece_valid` until accepted.
- `validate_done_flag` outside WAIT_VAL is ignored.
- `occupied` is sampled in the same cycle its address is driven. The address is registered; `occupied` is combinational from it.

## Configuration
- `PIECE_SEQ_HARD_DROP_EN` defined:
  - Adds input `hard_drop` (1 bit), sampled in ACTIVE.
  - After a hard drop, MOVE returns directly to FALL_CHK instead of ACTIVE, repeating until blocked, then locks.
  - `step` is ignored while dropping.
  - `hard_drop` and `step` in the same cycle: `hard_drop` wins.
- `PIECE_SEQ_HARD_DROP_EN` undefined: no `hard_drop` port; drops advance only on `step`.

## Test plan
- **Reset:** `rst` = 0 mid-FALL_CHK -> all outputs at reset values within the same cycle; IDLE with `piece_ready` = 1 after release.
- **Spawn clear:**
  - Stimulus: on an empty board, spawn cells (y,x) (0,3), (0,4), (0,5), (1,4), colour 24'hFF0000.
  - Required: ACTIVE after 5 cycles.
  - Then 19 steps -> the piece locks at rows 18/19; board[19][4] = 24'hFF0000; `locked` pulses; `lines_total` = 0.
- **Blocked by stack:**
  - Stimulus: board cell (19,4) pre-filled; spawn vertical I at x = 4, rows 0-3.
  - Required: lock with cells at rows 15-18, after 15 unblocked steps; the 16th step locks.
- **Line clear:**
  - Stimulus: row 19, x = 0..5, pre-filled; drop horizontal I at x = 6..9 to row 19.
  - Required: the board reports `lines_cleared` = 1; `lines_total` = 1; `piece_ready` returns.
- **Spawn collision:** spawn over occupied (0,4) -> GAME_OVER; `game_over` = 1; later `piece_valid` and `step` are ignored.
- **Hard drop** (`PIECE_SEQ_HARD_DROP_EN` defined): one `hard_drop` pulse on an empty board -> a flat piece spawned at rows 0/1 locks at rows 18/19, after 18 × 5 + 4 cycles of drop and checks, with no further `step`.

Source files
------------

// File: rtl/piece_sequencer.sv
// rtl/piece_sequencer.sv - falling-tetromino sequencer driving the board probe/write port
// Optional feature: define PIECE_SEQ_HARD_DROP_EN to add the hard_drop input.
module piece_sequencer #(
  parameter int COLOUR_W = 24,
  parameter int LINES_W  = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                piece_valid,
  input  logic [35:0]         piece_cells,
  input  logic [COLOUR_W-1:0] piece_colour,
  output logic                piece_ready,
  input  logic                step,
`ifdef PIECE_SEQ_HARD_DROP_EN
  input  logic                hard_drop,
`endif
  output logic [3:0]          board_x,
  output logic [4:0]          board_y,
  output logic [COLOUR_W-1:0] write_colour,
  output logic                validate_start,
  output logic                write_done,
  input  logic                occupied,
  input  logic [1:0]          lines_cleared,
  input  logic                validate_done_flag,
  output logic [35:0]         cur_cells,
  output logic                busy,
  output logic                locked,
  output logic                game_over,
  output logic [LINES_W-1:0]  lines_total
);

  typedef enum logic [3:0] {
    S_IDLE, S_SPAWN_CHK, S_ACTIVE, S_FALL_CHK, S_MOVE,
    S_WRITE, S_COMMIT, S_WAIT_VAL, S_GAME_OVER
  } state_t;

  state_t              state, state_nxt;
  logic [1:0]          k;
  logic [COLOUR_W-1:0] colour;
  logic                hit_acc;
  logic                hit;
  logic                dropping;
  logic                drop_req;
  logic [3:0]          cell_x;
  logic [4:0]          cell_y;
  logic [LINES_W:0]    lines_sum;

`ifdef PIECE_SEQ_HARD_DROP_EN
  assign drop_req = hard_drop;
`else
  assign drop_req = 1'b0;
`endif

  assign cell_x    = cur_cells[9*k +: 4];
  assign cell_y    = cur_cells[9*k+4 +: 5];
  assign lines_sum = {1'b0, lines_total} + (LINES_W+1)'(lines_cleared);

  // A cell at the floor is blocked regardless of what the board reports below it.
  always_comb begin
    hit = 1'b0;
    case (state)
      S_SPAWN_CHK: hit = occupied || (cell_x > 4'd9) || (cell_y > 5'd19);
      S_FALL_CHK:  hit = (cell_y == 5'd19) || occupied;
      default:     hit = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:      if (piece_valid) state_nxt = S_SPAWN_CHK;
      S_SPAWN_CHK: if (k == 2'd3) state_nxt = (hit_acc || hit) ? S_GAME_OVER : S_ACTIVE;
      S_ACTIVE:    if (drop_req || step) state_nxt = S_FALL_CHK;
      S_FALL_CHK:  if (k == 2'd3) state_nxt = (hit_acc || hit) ? S_WRITE : S_MOVE;
      S_MOVE:      state_nxt = dropping ? S_FALL_CHK : S_ACTIVE;
      S_WRITE:     if (k == 2'd3) state_nxt = S_COMMIT;
      S_COMMIT:    state_nxt = S_WAIT_VAL;
      S_WAIT_VAL:  if (validate_done_flag) state_nxt = S_IDLE;
      S_GAME_OVER: state_nxt = S_GAME_OVER;
      default:     state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    piece_ready    = (state == S_IDLE);
    busy           = !((state == S_IDLE) || (state == S_ACTIVE) || (state == S_GAME_OVER));
    game_over      = (state == S_GAME_OVER);
    board_x        = 4'd0;
    board_y        = 5'd0;
    write_colour   = '0;
    validate_start = 1'b0;
    write_done     = 1'b0;
    locked         = 1'b0;
    case (state)
      S_SPAWN_CHK: begin
        board_x = cell_x;
        board_y = cell_y;
      end
      S_FALL_CHK: begin
        board_x = cell_x;
        board_y = (cell_y == 5'd19) ? cell_y : cell_y + 5'd1;
      end
      S_WRITE: begin
        board_x        = cell_x;
        board_y        = cell_y;
        write_colour   = colour;
        validate_start = 1'b1;
      end
      S_COMMIT:   write_done = 1'b1;
      S_WAIT_VAL: locked     = validate_done_flag;
      default: ;
    endcase
  end

  // k wraps 3->0 on the last cell, so every cell-walking state is entered with k = 0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      k           <= 2'd0;
      cur_cells   <= '0;
      colour      <= '0;
      hit_acc     <= 1'b0;
      dropping    <= 1'b0;
      lines_total <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          k        <= 2'd0;
          hit_acc  <= 1'b0;
          dropping <= 1'b0;
          if (piece_valid) begin
            cur_cells <= piece_cells;
            colour    <= piece_colour;
          end
        end
        S_SPAWN_CHK, S_FALL_CHK: begin
          k       <= k + 2'd1;
          hit_acc <= (k == 2'd3) ? 1'b0 : (hit_acc | hit);
        end
        S_ACTIVE: if (drop_req) dropping <= 1'b1;
        S_MOVE: begin
          for (int i = 0; i < 4; i++)
            cur_cells[9*i+4 +: 5] <= cur_cells[9*i+4 +: 5] + 5'd1;
        end
        S_WRITE: k <= k + 2'd1;
        S_WAIT_VAL: begin
          if (validate_done_flag) begin
            lines_total <= lines_sum[LINES_W] ? {LINES_W{1'b1}} : lines_sum[LINES_W-1:0];
            dropping    <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
